// File: rtl/unified_mem_arb_pkg.sv
// Shared types for the unified-cache port arbiter: FSM states, requester ids
// and the load type used for every instruction fetch.
package unified_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } state_t;

   typedef enum logic {
      REQ_IF,
      REQ_D
   } req_id_t;

   localparam logic [2:0] LOAD_WORD = 3'b010;

endpackage

// File: rtl/unified_mem_arb_pick.sv
// Winner selection between fetch and data requesters, with a starvation
// streak that forces a fetch grant after STARVE_LIMIT data wins over a waiting fetch.
module unified_mem_arb_pick
   import unified_mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    if_req,
   input  logic    d_req,
   input  logic    grant_en,
   output req_id_t winner
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] r_streak;
   logic          w_starved;

   assign w_starved = (r_streak == LIMIT);

   always_comb begin
      winner = REQ_D;
      if (if_req && (!d_req || w_starved)) begin
         winner = REQ_IF;
      end
   end

   // The streak only counts data wins that actually made fetch wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_streak <= '0;
      end else if (grant_en) begin
         if (winner == REQ_IF) begin
            r_streak <= '0;
         end else if (if_req && !w_starved) begin
            r_streak <= r_streak + 1'b1;
         end
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares the single unified-cache port between instruction fetch and load/store,
// keeping one transaction in flight and registering every response.
module unified_mem_arbiter
   import unified_mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_strobe,
   input  logic [2:0]              d_load_type,
   output logic                    d_gnt,
   output logic                    d_done,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_strobe,
   output logic [2:0]              mem_load_type,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   state_t                  r_state;
   logic                    r_mem_req;
   logic                    r_mem_we;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [DATA_WIDTH-1:0]   r_mem_wdata;
   logic [DATA_WIDTH/8-1:0] r_mem_strobe;
   logic [2:0]              r_mem_load_type;
   logic                    r_if_rvalid;
   logic [DATA_WIDTH-1:0]   r_if_rdata;
   logic                    r_d_done;
   logic [DATA_WIDTH-1:0]   r_d_rdata;

   req_id_t w_winner;
   logic    w_grant_en;
   logic    w_if_win;
   logic    w_d_win;

   assign w_grant_en = (r_state == IDLE) && (if_req || d_req);
   assign w_if_win   = w_grant_en && (w_winner == REQ_IF);
   assign w_d_win    = w_grant_en && (w_winner == REQ_D);

   unified_mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .d_req    (d_req),
      .grant_en (w_grant_en),
      .winner   (w_winner)
   );

   // Grants are combinational so a requester learns of acceptance in the same cycle.
   assign if_gnt        = w_if_win;
   assign d_gnt         = w_d_win;
   assign mem_req       = r_mem_req;
   assign mem_we        = r_mem_we;
   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign mem_strobe    = r_mem_strobe;
   assign mem_load_type = r_mem_load_type;
   assign if_rvalid     = r_if_rvalid;
   assign if_rdata      = r_if_rdata;
   assign d_done        = r_d_done;
   assign d_rdata       = r_d_rdata;

   // A reset mid-transaction simply forgets it; the fields stay put outside BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         r_mem_req       <= 1'b0;
         r_mem_we        <= 1'b0;
         r_mem_addr      <= '0;
         r_mem_wdata     <= '0;
         r_mem_strobe    <= '0;
         r_mem_load_type <= '0;
         r_if_rvalid     <= 1'b0;
         r_if_rdata      <= '0;
         r_d_done        <= 1'b0;
         r_d_rdata       <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_d_done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_if_win) begin
                  r_mem_req       <= 1'b1;
                  r_mem_we        <= 1'b0;
                  r_mem_addr      <= if_addr;
                  r_mem_wdata     <= '0;
                  r_mem_strobe    <= '0;
                  r_mem_load_type <= LOAD_WORD;
                  r_state         <= BUSY_I;
               end else if (w_d_win) begin
                  r_mem_req       <= 1'b1;
                  r_mem_we        <= d_we;
                  r_mem_addr      <= d_addr;
                  r_mem_wdata     <= d_wdata;
                  r_mem_strobe    <= d_strobe;
                  r_mem_load_type <= d_load_type;
                  r_state         <= BUSY_D;
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_if_rvalid <= 1'b1;
                  r_if_rdata  <= mem_rdata;
                  r_state     <= IDLE;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_d_done  <= 1'b1;
                  if (!r_mem_we) begin
                     r_d_rdata <= mem_rdata;
                  end
                  r_state <= IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a transaction-level model predicts
// grants, cache-port transactions and responses; a monitor checks them as they appear.
module tb_unified_mem_arbiter;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int SL  = 4;
   localparam int SBW = DW / 8;

   logic           clk           = 1'b0;
   logic           rst           = 1'b1;
   logic           if_req        = 1'b0;
   logic [AW-1:0]  if_addr       = '0;
   logic           if_gnt;
   logic           if_rvalid;
   logic [DW-1:0]  if_rdata;
   logic           d_req         = 1'b0;
   logic           d_we          = 1'b0;
   logic [AW-1:0]  d_addr        = '0;
   logic [DW-1:0]  d_wdata       = '0;
   logic [SBW-1:0] d_strobe      = '0;
   logic [2:0]     d_load_type   = '0;
   logic           d_gnt;
   logic           d_done;
   logic [DW-1:0]  d_rdata;
   logic           mem_req;
   logic           mem_we;
   logic [AW-1:0]  mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic [SBW-1:0] mem_strobe;
   logic [2:0]     mem_load_type;
   logic           mem_ack       = 1'b0;
   logic [DW-1:0]  mem_rdata     = '0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_req        (if_req),
      .if_addr       (if_addr),
      .if_gnt        (if_gnt),
      .if_rvalid     (if_rvalid),
      .if_rdata      (if_rdata),
      .d_req         (d_req),
      .d_we          (d_we),
      .d_addr        (d_addr),
      .d_wdata       (d_wdata),
      .d_strobe      (d_strobe),
      .d_load_type   (d_load_type),
      .d_gnt         (d_gnt),
      .d_done        (d_done),
      .d_rdata       (d_rdata),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_strobe    (mem_strobe),
      .mem_load_type (mem_load_type),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata)
   );

   typedef struct {
      logic [AW-1:0]  addr;
      logic           we;
      logic [DW-1:0]  wdata;
      logic [SBW-1:0] strobe;
      logic [2:0]     lt;
   } memTxn_t;

   typedef struct {
      bit            isFetch;
      logic [DW-1:0] data;
   } resp_t;

   memTxn_t memQ[$];
   resp_t   respQ[$];
   bit      grantLog[$];

   int checks = 0;
   int passes = 0;

   // Requester intent: each request is held with its fields until granted.
   bit             ifPend = 0;
   logic [AW-1:0]  ifAddrV = '0;
   bit             dPend = 0;
   logic           dWeV = 0;
   logic [AW-1:0]  dAddrV = '0;
   logic [DW-1:0]  dWdataV = '0;
   logic [SBW-1:0] dStrobeV = '0;
   logic [2:0]     dLtV = '0;

   // Reference model state and bench knobs.
   bit            mBusy = 0;
   bit            mBusyFetch = 0;
   bit            mCurWe = 0;
   int            mAckWait = 0;
   int            mStreak = 0;
   logic [DW-1:0] mLastLoad = '0;
   int            forceWait = -1;
   bit            useFixed = 0;
   logic [DW-1:0] fixedData = '0;
   bit            idleAckOn = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: checks each cache-port transaction while mem_req is held and each response pulse.
   bit      prevMemReq = 0;
   bit      haveTxn = 0;
   memTxn_t curTxn;
   resp_t   curResp;
   always @(negedge clk) begin
      if (mem_req === 1'b1 && !prevMemReq) begin
         if (memQ.size() == 0) checkOutput("unexpectedMemReq", 64'(mem_req), 64'd0);
         else begin
            curTxn  = memQ.pop_front();
            haveTxn = 1;
         end
      end
      if (mem_req !== 1'b1) haveTxn = 0;
      if (haveTxn) begin
         checkOutput("memAddr", 64'(mem_addr), 64'(curTxn.addr));
         checkOutput("memWe", 64'(mem_we), 64'(curTxn.we));
         checkOutput("memWdata", 64'(mem_wdata), 64'(curTxn.wdata));
         checkOutput("memStrobe", 64'(mem_strobe), 64'(curTxn.strobe));
         checkOutput("memLoadType", 64'(mem_load_type), 64'(curTxn.lt));
      end
      if (if_rvalid === 1'b1 || d_done === 1'b1) begin
         if (respQ.size() == 0) checkOutput("unexpectedPulse", 64'({if_rvalid, d_done}), 64'd0);
         else begin
            curResp = respQ.pop_front();
            if (curResp.isFetch) begin
               checkOutput("ifRvalid", 64'({if_rvalid, d_done}), 64'b10);
               checkOutput("ifRdata", 64'(if_rdata), 64'(curResp.data));
            end else begin
               checkOutput("dDone", 64'({if_rvalid, d_done}), 64'b01);
               checkOutput("dRdata", 64'(d_rdata), 64'(curResp.data));
            end
         end
      end
      prevMemReq = (mem_req === 1'b1);
   end

   // One clock of stimulus, entered and left 1ns after a rising edge.
   task automatic applyStimulus();
      bit expIf, expD, fetchWins;
      memTxn_t t;
      resp_t r;
      if_req      = ifPend;
      if_addr     = ifAddrV;
      d_req       = dPend;
      d_we        = dWeV;
      d_addr      = dAddrV;
      d_wdata     = dWdataV;
      d_strobe    = dStrobeV;
      d_load_type = dLtV;
      mem_ack     = 1'b0;
      mem_rdata   = useFixed ? fixedData : $urandom;
      if (mBusy) begin
         if (mAckWait == 0) mem_ack = 1'b1;
         else mAckWait--;
      end else if (idleAckOn && $urandom_range(0, 2) == 0) begin
         mem_ack = 1'b1;
      end
      #1;
      expIf = 0;
      expD  = 0;
      if (mBusy) begin
         if (mem_ack) begin
            r.isFetch = mBusyFetch;
            r.data    = (!mBusyFetch && mCurWe) ? mLastLoad : mem_rdata;
            if (!mBusyFetch && !mCurWe) mLastLoad = mem_rdata;
            respQ.push_back(r);
            mBusy = 0;
         end
      end else if (ifPend || dPend) begin
         fetchWins = ifPend && (!dPend || mStreak == SL);
         expIf = fetchWins;
         expD  = !fetchWins;
         if (fetchWins) begin
            t = '{addr: ifAddrV, we: 1'b0, wdata: '0, strobe: '0, lt: 3'b010};
            mStreak = 0;
            ifPend = 0;
         end else begin
            t = '{addr: dAddrV, we: dWeV, wdata: dWdataV, strobe: dStrobeV, lt: dLtV};
            if (ifPend && mStreak < SL) mStreak++;
            mCurWe = dWeV;
            dPend = 0;
         end
         memQ.push_back(t);
         grantLog.push_back(fetchWins);
         mBusy      = 1;
         mBusyFetch = fetchWins;
         mAckWait   = (forceWait >= 0) ? forceWait : int'($urandom_range(0, 3));
      end
      checkOutput("ifGnt", 64'(if_gnt), 64'(expIf));
      checkOutput("dGnt", 64'(d_gnt), 64'(expD));
      @(posedge clk);
      #1;
   endtask

   task automatic newFetch(input logic [AW-1:0] a);
      ifPend  = 1;
      ifAddrV = a;
   endtask

   task automatic newData(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [SBW-1:0] sb, input logic [2:0] lt);
      dPend    = 1;
      dWeV     = we;
      dAddrV   = a;
      dWdataV  = wd;
      dStrobeV = sb;
      dLtV     = lt;
   endtask

   task automatic clearModel();
      mBusy     = 0;
      mStreak   = 0;
      mLastLoad = '0;
      ifPend    = 0;
      dPend     = 0;
      memQ.delete();
   endtask

   task automatic applyReset();
      rst = 1'b1;
      if_req = 1'b0;
      d_req = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearModel();
      checkOutput("rstGnts", 64'({if_gnt, d_gnt}), 64'd0);
      checkOutput("rstMemReq", 64'(mem_req), 64'd0);
      checkOutput("rstMemFields", 64'({mem_we, mem_addr, mem_strobe, mem_load_type}), 64'd0);
      checkOutput("rstMemWdata", 64'(mem_wdata), 64'd0);
      checkOutput("rstPulses", 64'({if_rvalid, d_done}), 64'd0);
      checkOutput("rstRdata", 64'({if_rdata, d_rdata}), 64'd0);
   endtask

   bit expOrder[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      applyReset();

      // Fetch only, one-cycle ack latency.
      useFixed = 1;
      fixedData = 32'h00500093;
      forceWait = 0;
      newFetch(16'h0040);
      applyStimulus();
      checkOutput("fetchMemReqCycle1", 64'(mem_req), 64'd1);
      applyStimulus();
      checkOutput("fetchRvalidCycle2", 64'(if_rvalid), 64'd1);
      checkOutput("fetchRdataCycle2", 64'(if_rdata), 64'h00500093);
      useFixed = 0;
      forceWait = -1;

      // Load and fetch requested together: data wins, fetch follows.
      newFetch(16'h0080);
      newData(1'b0, 16'h1004, 32'h0, 4'h0, 3'b000);
      applyStimulus();
      checkOutput("loadMemType", 64'(mem_load_type), 64'd0);
      checkOutput("loadMemAddr", 64'(mem_addr), 64'h1004);
      for (int i = 0; i < 20 && (ifPend || mBusy); i++) applyStimulus();
      checkOutput("loadThenFetchDone", 64'({ifPend, mBusy}), 64'd0);

      // Store held over a three-cycle ack delay.
      forceWait = 2;
      newData(1'b1, 16'h2008, 32'hAABBCCDD, 4'b0100, 3'b010);
      for (int i = 0; i < 10 && (dPend || mBusy); i++) applyStimulus();
      applyStimulus();
      checkOutput("storeDoneSettled", 64'(d_done), 64'd0);
      forceWait = -1;

      // Continuous contention shows the starvation pattern.
      applyReset();
      grantLog.delete();
      for (int i = 0; i < 200 && grantLog.size() < 10; i++) begin
         if (!ifPend) newFetch(16'(($urandom & 32'hFFFC)));
         if (!dPend) newData(1'b0, 16'($urandom), 32'h0, 4'h0, 3'b010);
         applyStimulus();
      end
      for (int i = 0; i < 10; i++) begin
         if (i < grantLog.size()) checkOutput($sformatf("grantOrder%0d", i), 64'(grantLog[i]), 64'(expOrder[i]));
         else checkOutput($sformatf("grantOrder%0d", i), 64'd2, 64'(expOrder[i]));
      end
      ifPend = 0;
      dPend = 0;
      for (int i = 0; i < 10 && mBusy; i++) applyStimulus();
      applyStimulus();

      // Reset in BUSY_D with the ack arriving one cycle late.
      newData(1'b0, 16'h3000, 32'h0, 4'h0, 3'b010);
      forceWait = 8;
      applyStimulus();
      applyStimulus();
      checkOutput("busyDMemReq", 64'(mem_req), 64'd1);
      rst = 1'b1;
      if_req = 1'b0;
      d_req = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_ack = 1'b1;
      clearModel();
      forceWait = -1;
      checkOutput("abandonMemReq", 64'(mem_req), 64'd0);
      checkOutput("abandonOutputs", 64'({d_done, if_rvalid, mem_addr, mem_load_type}), 64'd0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      checkOutput("lateAckIgnored", 64'({d_done, mem_req, d_rdata}), 64'd0);
      newFetch(16'h0100);
      applyStimulus();

      // Acks pulsed while idle with nothing requested.
      for (int i = 0; i < 6 && mBusy; i++) applyStimulus();
      applyStimulus();
      mem_ack = 1'b1;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      checkOutput("idleAckNoEffect", 64'({if_rvalid, d_done, mem_req}), 64'd0);

      // Randomized traffic with withdrawals and stray idle acks.
      idleAckOn = 1;
      for (int c = 0; c < 400; c++) begin
         if (!ifPend && $urandom_range(0, 99) < 40) newFetch(16'(($urandom & 32'hFFFC)));
         else if (ifPend && $urandom_range(0, 19) == 0) ifPend = 0;
         if (!dPend && $urandom_range(0, 99) < 60)
            newData(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 3'($urandom));
         else if (dPend && $urandom_range(0, 19) == 0) dPend = 0;
         applyStimulus();
      end
      idleAckOn = 0;
      ifPend = 0;
      dPend = 0;
      for (int i = 0; i < 20 && mBusy; i++) applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("drained", 64'(respQ.size() + memQ.size() + int'(mBusy)), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
